seq_magnitude_cmp: RTL and testbench

Parametrised, multi-cycle magnitude comparator. It is the successor to the fixed 2-bit greater-than circuit.
- Compares two W-bit operands MSB-first, DIGIT_W bits per clock, under a start/ready/done handshake.
- Produces registered gt/eq/lt flags and supports both unsigned and two's-complement operands.
- Intended for datapaths where a wide single-cycle comparator would limit timing.

---
 rtl/seq_magnitude_cmp_pkg.sv | 22 ++
 rtl/seq_cmp_defs.vh | 20 ++
 rtl/seq_magnitude_cmp_digit_cmp.sv | 29 ++
 rtl/seq_magnitude_cmp.sv | 138 +++++++++++++
 tb/tb_seq_magnitude_cmp.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/seq_magnitude_cmp_pkg.sv
`default_nettype none
// ============================================================================
// seq_magnitude_cmp_pkg
// Shared state type and sizing helper for the sequential magnitude comparator.
// Rev 1.0
// ============================================================================
package seq_magnitude_cmp_pkg;

  `include "seq_cmp_defs.vh"

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_CMP  = S_CMP,
    ST_DONE = S_DONE
  } state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_cmp_defs.vh
`default_nettype none
// ============================================================================
// seq_cmp_defs.vh
// State encodings and the digit-width check for the sequential comparator.
// Rev 1.0
// ============================================================================
`ifndef SEQ_CMP_DEFS_VH
`define SEQ_CMP_DEFS_VH

localparam logic [1:0] S_IDLE = 2'd0;
localparam logic [1:0] S_CMP  = 2'd1;
localparam logic [1:0] S_DONE = 2'd2;

`define SEQ_CMP_CHECK_DIGIT_W(W_, D_) \
  if ((D_) < 1 || (D_) > (W_) || ((W_) % (D_)) != 0) begin : g_digit_w_check \
    $error("seq_magnitude_cmp: DIGIT_W must be in 1..W and divide W"); \
  end

`endif
`default_nettype wire

// File: rtl/seq_magnitude_cmp_digit_cmp.sv
`default_nettype none
// ============================================================================
// digit_cmp
// Combinational DIGIT_W-bit unsigned compare, scanning MSB-first.
// Rev 1.0
// ============================================================================
module digit_cmp #(
  parameter int DIGIT_W = 2
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic               dgt,
  output logic               deq
);

  // The highest differing bit decides; a 1 in a there means a > b.
  always_comb begin
    dgt = 1'b0;
    deq = 1'b1;
    for (int i = DIGIT_W - 1; i >= 0; i--) begin
      if (deq && (a[i] != b[i])) begin
        dgt = a[i];
        deq = 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_magnitude_cmp.sv
`default_nettype none
// ============================================================================
// seq_magnitude_cmp
// Multi-cycle MSB-first magnitude comparator, DIGIT_W bits per clock,
// unsigned or two's-complement. SEQ_CMP_EARLY_EXIT_EN ends on first difference.
// Rev 1.0
// ============================================================================
`include "seq_cmp_defs.vh"

module seq_magnitude_cmp
  import seq_magnitude_cmp_pkg::*;
#(
  parameter int W       = 8,
  parameter int DIGIT_W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         signed_mode,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         ready,
  output logic         done_tick,
  output logic         gt,
  output logic         eq,
  output logic         lt
);

  `SEQ_CMP_CHECK_DIGIT_W(W, DIGIT_W)

  localparam int N     = W / DIGIT_W;
  localparam int CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N - 1);

  state_t             r_state;
  state_t             w_next;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic               r_signed;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_decided;
  logic               r_dec_gt;
  logic [DIGIT_W-1:0] w_a_dig;
  logic [DIGIT_W-1:0] w_b_dig;
  logic               w_dgt;
  logic               w_deq;
  logic               w_last;
  logic               w_finish;

  // Flipping both sign bits maps two's-complement order onto unsigned order.
  always_comb begin
    w_a_dig = r_a[W-1 -: DIGIT_W];
    w_b_dig = r_b[W-1 -: DIGIT_W];
    if (r_signed && (r_cnt == '0)) begin
      w_a_dig[DIGIT_W-1] = ~w_a_dig[DIGIT_W-1];
      w_b_dig[DIGIT_W-1] = ~w_b_dig[DIGIT_W-1];
    end
  end

  digit_cmp #(
    .DIGIT_W (DIGIT_W)
  ) u_digit_cmp (
    .a   (w_a_dig),
    .b   (w_b_dig),
    .dgt (w_dgt),
    .deq (w_deq)
  );

  assign w_last   = (r_cnt == C_LAST);
  assign ready    = (r_state == ST_IDLE);
  assign w_finish = (r_state == ST_CMP) && (w_next == ST_DONE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_CMP;
`ifdef SEQ_CMP_EARLY_EXIT_EN
      ST_CMP:  if (w_last || !w_deq) w_next = ST_DONE;
`else
      ST_CMP:  if (w_last) w_next = ST_DONE;
`endif
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Flags load on the edge into DONE so they are valid alongside done_tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a       <= '0;
      r_b       <= '0;
      r_signed  <= 1'b0;
      r_cnt     <= '0;
      r_decided <= 1'b0;
      r_dec_gt  <= 1'b0;
      done_tick <= 1'b0;
      gt        <= 1'b0;
      eq        <= 1'b0;
      lt        <= 1'b0;
    end else begin
      done_tick <= w_finish;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a       <= a;
            r_b       <= b;
            r_signed  <= signed_mode;
            r_cnt     <= '0;
            r_decided <= 1'b0;
            r_dec_gt  <= 1'b0;
          end
        end
        ST_CMP: begin
          r_a   <= r_a << DIGIT_W;
          r_b   <= r_b << DIGIT_W;
          r_cnt <= r_cnt + 1'b1;
          if (!r_decided && !w_deq) begin
            r_decided <= 1'b1;
            r_dec_gt  <= w_dgt;
          end
          if (w_finish) begin
            gt <= r_decided ? r_dec_gt  : (!w_deq &&  w_dgt);
            lt <= r_decided ? !r_dec_gt : (!w_deq && !w_dgt);
            eq <= !r_decided && w_deq;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_magnitude_cmp.sv
`default_nettype none
// ============================================================================
// tb_seq_magnitude_cmp
// Randomised and directed checks of three comparator configurations
// against an arithmetic reference model.
// Rev 1.0
// ============================================================================
module tb_seq_magnitude_cmp;

  logic       clk = 1'b0;
  logic       reset;
  logic       t_start [3];
  logic       t_sm    [3];
  logic [7:0] t_a     [3];
  logic [7:0] t_b     [3];
  logic [2:0] d_ready, d_done, d_gt, d_eq, d_lt;
  int         n_total = 0;
  int         n_bad   = 0;

  always #5 clk = ~clk;

  // Instance 0: W=8/DIGIT_W=2, instance 1: W=4/DIGIT_W=2, instance 2: W=4/DIGIT_W=1.
  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int WI = (gi == 0) ? 8 : 4;
    localparam int DI = (gi == 2) ? 1 : 2;
    seq_magnitude_cmp #(.W(WI), .DIGIT_W(DI)) u_dut (
      .clk         (clk),
      .reset       (reset),
      .start       (t_start[gi]),
      .signed_mode (t_sm[gi]),
      .a           (t_a[gi][WI-1:0]),
      .b           (t_b[gi][WI-1:0]),
      .ready       (d_ready[gi]),
      .done_tick   (d_done[gi]),
      .gt          (d_gt[gi]),
      .eq          (d_eq[gi]),
      .lt          (d_lt[gi])
    );
  end

  function automatic int w_of(input int idx);
    return (idx == 0) ? 8 : 4;
  endfunction

  function automatic int d_of(input int idx);
    return (idx == 2) ? 1 : 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // rel: +1 a>b, 0 equal, -1 a<b. lat: edges from acceptance to done_tick visible.
  function automatic void model(input int idx, input int a, input int b, input bit sm,
                                output int rel, output int lat);
    int w, d, mask, av, bv, x, p;
    w    = w_of(idx);
    d    = d_of(idx);
    mask = (1 << w) - 1;
    av   = a & mask;
    bv   = b & mask;
    if (sm) begin
      if (av >= (1 << (w - 1))) av -= (1 << w);
      if (bv >= (1 << (w - 1))) bv -= (1 << w);
    end
    rel = (av > bv) ? 1 : ((av < bv) ? -1 : 0);
    lat = w / d + 1;
    x   = (a ^ b) & mask;
    p   = w - 1;
`ifdef SEQ_CMP_EARLY_EXIT_EN
    if (x != 0) begin
      while (((x >> p) & 1) == 0) p--;
      lat = (w - 1 - p) / d + 2;
    end
`endif
  endfunction

  task automatic issue(input int idx, input int a, input int b, input bit sm);
    t_a[idx]     = a[7:0];
    t_b[idx]     = b[7:0];
    t_sm[idx]    = sm;
    t_start[idx] = 1'b1;
  endtask

  // Called just after an edge with the DUT idle; returns just after the
  // edge following done_tick (DUT idle again). Inputs are scrambled while busy.
  task automatic run_op(input int idx, input int a, input int b, input bit sm, input bit hold);
    int lat, rel, elat;
    chk("ready_idle", d_ready[idx], 1);
    issue(idx, a, b, sm);
    lat = 0;
    while (1) begin
      @(posedge clk);
      #1;
      lat++;
      if (!hold) t_start[idx] = 1'b0;
      t_a[idx]  = 8'($urandom);
      t_b[idx]  = 8'($urandom);
      t_sm[idx] = 1'($urandom);
      if (d_done[idx] || lat > 40) break;
      chk("ready_busy", d_ready[idx], 0);
    end
    model(idx, a, b, sm, rel, elat);
    chk("latency", lat, elat);
    chk("ready_done", d_ready[idx], 0);
    chk("gt", d_gt[idx], (rel == 1) ? 1 : 0);
    chk("eq", d_eq[idx], (rel == 0) ? 1 : 0);
    chk("lt", d_lt[idx], (rel == -1) ? 1 : 0);
    chk("onehot", 32'(d_gt[idx]) + 32'(d_eq[idx]) + 32'(d_lt[idx]), 1);
    @(posedge clk);
    #1;
    chk("pulse_once", d_done[idx], 0);
    chk("ready_back", d_ready[idx], 1);
    chk("hold_gt", d_gt[idx], (rel == 1) ? 1 : 0);
    chk("hold_lt", d_lt[idx], (rel == -1) ? 1 : 0);
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      t_start[i] = 1'b0;
      t_sm[i]    = 1'b0;
      t_a[i]     = 8'h00;
      t_b[i]     = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rst_gt", d_gt[i], 0);
      chk("rst_eq", d_eq[i], 0);
      chk("rst_lt", d_lt[i], 0);
      chk("rst_done", d_done[i], 0);
      chk("rst_ready", d_ready[i], 1);
    end

    // Directed cases on the 8-bit instance.
    run_op(0, 8'h5A, 8'h5A, 1'b0, 1'b0);
    run_op(0, 8'h80, 8'h7F, 1'b0, 1'b0);
    run_op(0, 8'h80, 8'h7F, 1'b1, 1'b0);
    run_op(0, 8'hC0, 8'h40, 1'b0, 1'b0);
    run_op(0, 8'h12, 8'h13, 1'b0, 1'b0);
    run_op(0, 8'h7F, 8'hFF, 1'b1, 1'b0);

    // start held high throughout; second op accepted on the IDLE cycle.
    run_op(0, 8'h3C, 8'hC3, 1'b0, 1'b1);
    run_op(0, 8'hF0, 8'h0F, 1'b1, 1'b0);

    // Reset in the second CMP cycle discards the operation.
    run_op(0, 8'h90, 8'h10, 1'b0, 1'b0);
    issue(0, 8'h5A, 8'h3C, 1'b0);
    @(posedge clk);
    #1;
    t_start[0] = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort_gt", d_gt[0], 0);
    chk("abort_eq", d_eq[0], 0);
    chk("abort_lt", d_lt[0], 0);
    chk("abort_ready", d_ready[0], 1);
    for (int c = 0; c < 8; c++) begin
      chk("abort_no_done", d_done[0], 0);
      @(posedge clk);
      #1;
    end
    run_op(0, 8'h01, 8'h02, 1'b0, 1'b0);

    // Randomised operands on the 8-bit instance.
    for (int r = 0; r < 300; r++) begin
      int ra, rb;
      ra = $urandom_range(0, 255);
      rb = ($urandom_range(0, 7) == 0) ? ra : $urandom_range(0, 255);
      run_op(0, ra, rb, 1'($urandom), 1'b0);
    end

    // Exhaustive 4-bit sweeps for both digit widths and both modes.
    for (int idx = 1; idx < 3; idx++)
      for (int m = 0; m < 2; m++)
        for (int ea = 0; ea < 16; ea++)
          for (int eb = 0; eb < 16; eb++)
            run_op(idx, ea, eb, m[0], 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
